// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory-port responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_mem_pkg;

  localparam int WORD_W      = 16;  // storage word and data bus width
  localparam int ADDR_W      = 16;  // CPU byte-address width
  localparam int LATENCY_DEF = 4;   // default accept-to-complete cycles
  localparam int CNT_W       = 4;   // enough for LATENCY-1 up to 14

  typedef logic [WORD_W-1:0] word_t;

  // Two-state responder: IDLE accepts a request, WAIT counts down the latency.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// CPU memory-port bundle: request strobe/attributes out, data/status back.
// Latency: n/a (wiring only).
// Backpressure: the slave drops busy/ready to stall; no request queueing.
// Ports: master = CPU side (drives enable/wr/addr/data_in),
//        slave  = responder side (drives data_out/ready/busy/valid).
interface mem_responder_if;
  import cpu_mem_pkg::*;

  logic              enable;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  word_t             data_in;
  word_t             data_out;
  logic              ready;
  logic              busy;
  logic              valid;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, ready, busy, valid
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, ready, busy, valid
  );

endinterface

// File: rtl/mem_responder_lat_counter.sv
// Latency down-counter: loads a start value, counts to zero, then holds.
// Latency: zero flag reflects the current count (combinational from state).
// Backpressure: none; load has priority over counting.
// Ports: clk, rst_n, load/load_value (start), run (count enable), zero (count==0).
module lat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         run,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency single-port memory responder for a CPU memory port.
// Latency: LATENCY cycles from acceptance to the registered valid pulse.
// Backpressure: busy while an access is in flight; requests seen then are dropped.
// Ports: clk, rst_n (async active-low), bus (mem_responder_if.slave).
module mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int LATENCY    = LATENCY_DEF,  // legal 1..15
  parameter int DEPTH_LOG2 = 8             // words = 2**DEPTH_LOG2
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_responder_if.slave  bus
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [CNT_W-1:0]  LOAD_VAL = CNT_W'(LATENCY - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic                    accept;
  logic                    complete;
  logic                    cnt_zero;

  // Request attributes captured at acceptance so later input changes are ignored.
  logic [DEPTH_LOG2-1:0]   lat_addr;
  word_t                   lat_data;
  logic                    lat_wr;

  // Storage is deliberately left out of reset so contents survive it.
  word_t                   mem [0:DEPTH-1];

  // Only addr[DEPTH_LOG2:1] selects a word; the remaining bits are don't-care.
  logic                    addr_unused;
  assign addr_unused = ^bus.addr;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.enable) state_nxt = WAIT;
      WAIT:    if (cnt_zero)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    accept    = 1'b0;
    complete  = 1'b0;
    bus.ready = 1'b0;
    bus.busy  = 1'b1;
    case (state)
      IDLE: begin
        accept    = bus.enable;
        bus.ready = 1'b1;
        bus.busy  = 1'b0;
      end
      WAIT: begin
        complete  = cnt_zero;
      end
      default: ;
    endcase
  end

  // Loaded with LATENCY-1 so that the zero edge lands exactly LATENCY edges
  // after acceptance (LATENCY=1 completes on the very next edge).
  lat_counter #(
    .W (CNT_W)
  ) u_lat_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept),
    .load_value (LOAD_VAL),
    .run        (state == WAIT),
    .zero       (cnt_zero)
  );

  // ---------------- request capture and response ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_addr     <= '0;
      lat_data     <= '0;
      lat_wr       <= 1'b0;
      bus.valid    <= 1'b0;
      bus.data_out <= '0;
    end else begin
      if (accept) begin
        lat_addr <= bus.addr[DEPTH_LOG2:1];
        lat_data <= bus.data_in;
        lat_wr   <= bus.wr;
      end
      bus.valid <= complete;
      // data_out only moves on read completion; it holds through everything else.
      if (complete && !lat_wr) begin
        bus.data_out <= mem[lat_addr];
      end
    end
  end

  // Write commit happens only at completion; a reset mid-access drops state
  // to IDLE asynchronously, so the commit never fires.
  always_ff @(posedge clk) begin
    if (complete && lat_wr) begin
      mem[lat_addr] <= lat_data;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one LATENCY=4 and one LATENCY=1 instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_responder;
  import cpu_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_responder_if i4 ();
  mem_responder_if i1 ();

  mem_responder #(.LATENCY(4), .DEPTH_LOG2(8)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (i4.slave)
  );

  mem_responder #(.LATENCY(1), .DEPTH_LOG2(8)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (i1.slave)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Four edges after acceptance on the LATENCY=4 instance: busy for the first
  // three, valid exactly on the fourth.
  task automatic wait4(input string tag);
    for (int k = 1; k <= 4; k++) begin
      tick;
      chk1({tag, "_valid"}, i4.valid, (k == 4));
      chk1({tag, "_busy"},  i4.busy,  (k < 4));
    end
  endtask

  // One full access on the LATENCY=4 instance; inputs are scrambled right
  // after acceptance to show the in-flight access uses the latched values.
  task automatic access4(input logic w, input logic [15:0] a, input logic [15:0] d,
                         input string tag);
    i4.enable  = 1'b1;
    i4.wr      = w;
    i4.addr    = a;
    i4.data_in = d;
    tick;
    chk1({tag, "_acc_busy"},  i4.busy,  1'b1);
    chk1({tag, "_acc_ready"}, i4.ready, 1'b0);
    i4.enable  = 1'b0;
    i4.wr      = ~w;
    i4.addr    = ~a;
    i4.data_in = ~d;
    wait4(tag);
  endtask

  initial begin
    rst_n      = 1'b0;
    i4.enable  = 1'b0; i4.wr = 1'b0; i4.addr = '0; i4.data_in = '0;
    i1.enable  = 1'b0; i1.wr = 1'b0; i1.addr = '0; i1.data_in = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_valid", i4.valid,    1'b0);
    chk ("rst_dout",  i4.data_out, 16'h0000);
    chk1("rst_ready", i4.ready,    1'b1);
    chk1("rst_busy",  i4.busy,     1'b0);
    chk ("rst_dout1", i1.data_out, 16'h0000);
    rst_n = 1'b1;

    // Write BEEF then read it back; first acceptance on the first edge after release
    access4(1'b1, 16'h0010, 16'hBEEF, "wr_beef");
    chk("wr_beef_dout_hold", i4.data_out, 16'h0000);
    access4(1'b0, 16'h0010, 16'h0000, "rd_beef");
    chk("rd_beef_dout", i4.data_out, 16'hBEEF);

    // Continuous enable: second request only taken after completion
    access4(1'b1, 16'h0002, 16'h1111, "pre2");
    access4(1'b1, 16'h0004, 16'h2222, "pre4");
    i4.enable = 1'b1; i4.wr = 1'b0; i4.addr = 16'h0002;
    tick;
    chk1("str_acc1_busy", i4.busy, 1'b1);
    i4.addr = 16'h0004;
    wait4("str1");
    chk ("str1_dout",  i4.data_out, 16'h1111);
    chk1("str1_ready", i4.ready,    1'b1);
    tick;
    chk1("str_acc2_busy",  i4.busy,  1'b1);
    chk1("str_acc2_valid", i4.valid, 1'b0);
    i4.enable = 1'b0;
    wait4("str2");
    chk("str2_dout", i4.data_out, 16'h2222);

    // Address wrap and ignored bit 0
    access4(1'b1, 16'h0206, 16'h1234, "wr_wrap");
    access4(1'b0, 16'h0006, 16'h0000, "rd_wrap");
    chk("wrap_dout", i4.data_out, 16'h1234);
    access4(1'b0, 16'h0007, 16'h0000, "rd_odd");
    chk("odd_dout", i4.data_out, 16'h1234);

    // Reset mid-write aborts the access and leaves storage intact
    access4(1'b1, 16'h0020, 16'h5555, "wr_5555");
    chk("hold_thru_wr", i4.data_out, 16'h1234);
    i4.enable = 1'b1; i4.wr = 1'b1; i4.addr = 16'h0020; i4.data_in = 16'hAAAA;
    tick;
    i4.enable = 1'b0;
    tick;
    rst_n = 1'b0;
    #1;
    chk1("abort_valid", i4.valid,    1'b0);
    chk ("abort_dout",  i4.data_out, 16'h0000);
    chk1("abort_busy",  i4.busy,     1'b0);
    tick;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk1("abort_no_valid", i4.valid, 1'b0);
    end
    access4(1'b0, 16'h0020, 16'h0000, "rd_after_abort");
    chk("abort_storage", i4.data_out, 16'h5555);

    // LATENCY=1: prefill, then read/write/read back-to-back
    i1.enable = 1'b1; i1.wr = 1'b1; i1.addr = 16'h0040; i1.data_in = 16'hC0DE;
    tick;
    chk1("l1_pre_busy", i1.busy, 1'b1);
    i1.enable = 1'b0;
    tick;
    chk1("l1_pre_valid", i1.valid, 1'b1);
    chk1("l1_pre_busy0", i1.busy,  1'b0);

    i1.enable = 1'b1; i1.wr = 1'b0; i1.addr = 16'h0040;
    tick;
    chk1("l1_r1_acc_busy",  i1.busy,  1'b1);
    chk1("l1_r1_acc_valid", i1.valid, 1'b0);
    i1.wr = 1'b1; i1.data_in = 16'h7777;
    tick;
    chk1("l1_r1_valid", i1.valid,    1'b1);
    chk ("l1_r1_dout",  i1.data_out, 16'hC0DE);
    chk1("l1_r1_ready", i1.ready,    1'b1);
    tick;
    chk1("l1_w_acc_busy",  i1.busy,  1'b1);
    chk1("l1_w_acc_valid", i1.valid, 1'b0);
    i1.wr = 1'b0;
    tick;
    chk1("l1_w_valid",     i1.valid,    1'b1);
    chk ("l1_w_dout_hold", i1.data_out, 16'hC0DE);
    tick;
    chk1("l1_r2_acc_busy", i1.busy,     1'b1);
    chk ("l1_r2_dout_old", i1.data_out, 16'hC0DE);
    i1.enable = 1'b0;
    tick;
    chk1("l1_r2_valid", i1.valid,    1'b1);
    chk ("l1_r2_dout",  i1.data_out, 16'h7777);
    tick;
    chk1("l1_r2_pulse_end", i1.valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 4, is the cycles from request acceptance to completion; legal range 1..15.
REQ-002 Parameter DEPTH_LOG2, default 8, is log2 of the storage depth in 16-bit words.
REQ-003 Port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port enable, input, 1 bit: request strobe from the CPU memory port.
REQ-006 Port wr, input, 1 bit: 1 = write request, 0 = read request; qualified by enable.
REQ-007 Port addr, input, 16 bits: byte address; bit 0 is ignored.
REQ-008 Port data_in, input, 16 bits: write data.
REQ-009 Port data_out, output, 16 bits: read data, registered.
REQ-010 Port ready, output, 1 bit: combinational; high when state is IDLE.
REQ-011 Port busy, output, 1 bit: the inverse of ready, used as the CPU stall source.
REQ-012 Port valid, output, 1 bit: registered one-cycle completion pulse for both reads and writes.

Function
REQ-013 The FSM SHALL have two states, IDLE and WAIT.
REQ-014 A request SHALL be accepted at a rising edge only when state is IDLE and enable=1. Acceptance latches addr[DEPTH_LOG2:1], data_in and wr, loads the latency counter with LATENCY-1, and moves the FSM to WAIT.
REQ-015 Requests with enable=1 while state is WAIT SHALL be ignored: not queued, and with no effect on storage or outputs.
REQ-016 In WAIT, the counter SHALL decrement by 1 per cycle while it is non-zero.
REQ-017 At the edge where the counter is 0 in WAIT (acceptance edge E0 + LATENCY), the block SHALL complete the access:
- valid=1 for exactly one cycle;
- state returns to IDLE;
- a read loads data_out with the stored word;
- a write commits the latched data to storage.
REQ-018 The earliest next acceptance SHALL be at E0+LATENCY+1, giving a throughput of one access per LATENCY+1 cycles.
REQ-019 data_out SHALL hold its value through writes, idle cycles and busy cycles; only read completion changes it.
REQ-020 Addresses SHALL wrap modulo 2^DEPTH_LOG2 words; upper address bits are ignored and no error is raised.
REQ-021 A read SHALL return the value of the most recently completed write to the same word.
REQ-022 Inputs changing after acceptance SHALL NOT affect the in-flight access.
REQ-023 With LATENCY=1, completion SHALL occur at the edge immediately after acceptance.

Reset
REQ-024 On rst_n=0, the block SHALL asynchronously force state=IDLE, counter=0, valid=0 and data_out=16'h0000.
REQ-025 Reset during WAIT SHALL abort the access: no write commit and no valid pulse.
REQ-026 Storage contents SHALL NOT be cleared by reset.
REQ-027 The first acceptance after reset release SHALL be possible at the first rising edge with rst_n=1.

Structure
REQ-028 The state enum (IDLE, WAIT), the default LATENCY and the word width (16) SHALL live in the shared package cpu_mem_pkg.
REQ-029 The latency down-counter SHALL be a sub-module named lat_counter, with ports load, load_value, and zero flag.
REQ-030 Storage SHALL be a single-port register array inside mem_responder, with no byte enables.

Verification
REQ-031 With LATENCY=4: write 16'hBEEF to 0x0010, then read 0x0010.
- Required: the write's valid pulse 4 cycles after acceptance.
- Required: the read's valid pulse 4 cycles after acceptance, with data_out=16'hBEEF.
- Required: busy high for exactly 4 cycles per access.
REQ-032 Hold enable=1 continuously with reads of 0x0002, 0x0004 (LATENCY=4).
- Required: acceptances exactly 5 cycles apart.
- Required: the mid-WAIT request is ignored.
REQ-033 With DEPTH_LOG2=8: write 16'h1234 to 0x0206, then read 0x0006.
- Required: data_out=16'h1234 (wrap-around).
- Required: a read of 0x0007 also returns 16'h1234 (bit 0 ignored).
REQ-034 Accept a write of 16'hAAAA to 0x0020 (prior value 16'h5555), then assert rst_n=0 for 1 cycle at counter=2.
- Required: no valid pulse.
- Required: data_out=0.
- Required: a subsequent read of 0x0020 returns 16'h5555.
REQ-035 With LATENCY=1: read, write, read back-to-back.
- Required: valid 1 cycle after each acceptance.
- Required: acceptances 2 cycles apart.
- Required: data_out holds the previous read value through the write.
